// File: rtl/control_unit.sv
// Hardwired control sequencer for the datapath: fetch T0-T2, then decodes IR for the
// register ALU, MUL/DIV and NEG/NOT classes. Includes stop/halt and illegal-opcode handling.
module control_unit #(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        Read,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        AND,
    output logic        OR,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        run,
    output logic        illegal
);

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned NREG   = 16;
    localparam int unsigned ALU_W  = 13;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_ILLEGAL, C_ALU3, C_MULDIV, C_UNARY
    } class_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               illegal_q, illegal_d;

    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   ra, rb, rc;
    class_t             op_class;
    logic [ALU_W-1:0]   op_sel;
    logic [ALU_W-1:0]   alu_c;
    logic               ir_unused_c;

    function automatic logic [NREG-1:0] reg_sel(input logic [REG_W-1:0] r);
        return NREG'(1) << r;
    endfunction

    assign opcode      = ir[31:27];
    assign ra          = ir[26:23];
    assign rb          = ir[22:19];
    assign rc          = ir[18:15];
    assign ir_unused_c = ^ir[14:0];

    // Opcode -> instruction class and one-hot ALU select {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}
    always_comb begin
        op_class = C_ILLEGAL;
        op_sel   = '0;
        case (opcode)
            5'b00011: begin op_class = C_ALU3;   op_sel = 13'h0400; end
            5'b00100: begin op_class = C_ALU3;   op_sel = 13'h0200; end
            5'b00101: begin op_class = C_ALU3;   op_sel = 13'h1000; end
            5'b00110: begin op_class = C_ALU3;   op_sel = 13'h0800; end
            5'b00111: begin op_class = C_ALU3;   op_sel = 13'h0008; end
            5'b01000: begin op_class = C_ALU3;   op_sel = 13'h0004; end
            5'b01001: begin op_class = C_ALU3;   op_sel = 13'h0040; end
            5'b01010: begin op_class = C_ALU3;   op_sel = 13'h0020; end
            5'b01011: begin op_class = C_ALU3;   op_sel = 13'h0010; end
            5'b01111: begin op_class = C_MULDIV; op_sel = 13'h0080; end
            5'b10000: begin op_class = C_MULDIV; op_sel = 13'h0100; end
            5'b10001: begin op_class = C_UNARY;  op_sel = 13'h0002; end
            5'b10010: begin op_class = C_UNARY;  op_sel = 13'h0001; end
            default:  begin op_class = C_ILLEGAL; op_sel = '0; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RESET;
            hold_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and Moore strobes from present state and IR
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        illegal_d = illegal_q;
        Rin       = '0;
        Rout      = '0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        Read      = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        run       = 1'b1;
        case (state_q)
            S_RESET: begin
                run = 1'b0;
                if (hold_q >= HOLD_W'(RESET_PC_HOLD)) begin
                    state_d = S_T0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_T0: begin
                IncPC   = 1'b1;
                PCin    = 1'b1;
                MARin   = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                case (op_class)
                    C_ALU3: begin
                        Rout    = reg_sel(rb);
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                    C_MULDIV: begin
                        Rout    = reg_sel(ra);
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                    C_UNARY: begin
                        Rout    = reg_sel(rb);
                        Zin     = 1'b1;
                        state_d = S_T4;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_ALU3: begin
                        Rout    = reg_sel(rc);
                        Zin     = 1'b1;
                        state_d = S_T5;
                    end
                    C_MULDIV: begin
                        Rout    = reg_sel(rb);
                        Zin     = 1'b1;
                        state_d = S_T5;
                    end
                    C_UNARY: begin
                        Zlowout = 1'b1;
                        Rin     = reg_sel(ra);
                        state_d = stop ? S_HALT : S_T0;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (op_class == C_MULDIV) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = reg_sel(ra);
                    state_d = stop ? S_HALT : S_T0;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = stop ? S_HALT : S_T0;
            end
            S_HALT: begin
                run = 1'b0;
                if (!stop && !illegal_q) begin
                    state_d = S_T0;
                end
            end
            default: begin
                run     = 1'b0;
                state_d = S_RESET;
            end
        endcase
    end

    // ALU select is only driven while Z is loading
    assign alu_c = Zin ? op_sel : '0;
    assign {AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} = alu_c;

    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit: per-cycle expected strobes plus
// hand sequences for asynchronous reset behaviour.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic        stop;
    logic [15:0] Rin, Rout;
    logic PCin, IncPC, MARin, MDRin, Read, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic a_and, a_or, a_add, a_sub, a_mul, a_div, a_shr, a_shra, a_shl, a_ror, a_rol, a_neg, a_not;
    logic run, illegal;

    control_unit #(.RESET_PC_HOLD(1)) dut (
        .clk(clk), .reset(reset), .ir(ir), .stop(stop),
        .Rin(Rin), .Rout(Rout),
        .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .Read(Read),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .AND(a_and), .OR(a_or), .ADD(a_add), .SUB(a_sub), .MUL(a_mul), .DIV(a_div),
        .SHR(a_shr), .SHRA(a_shra), .SHL(a_shl), .ROR(a_ror), .ROL(a_rol),
        .NEG(a_neg), .NOT(a_not),
        .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Strobe word order: {PCin,IncPC,MARin,MDRin,Read,MDRout,IRin,Yin,Zin,Zlowout,Zhighout,HIin,LOin}
    localparam logic [12:0] S_PCIN = 13'h1000, S_INCPC = 13'h0800, S_MARIN = 13'h0400;
    localparam logic [12:0] S_MDRIN = 13'h0200, S_READ = 13'h0100, S_MDROUT = 13'h0080;
    localparam logic [12:0] S_IRIN = 13'h0040, S_YIN = 13'h0020, S_ZIN = 13'h0010;
    localparam logic [12:0] S_ZLO = 13'h0008, S_ZHI = 13'h0004, S_HIIN = 13'h0002, S_LOIN = 13'h0001;
    localparam logic [12:0] S_T0 = S_PCIN | S_INCPC | S_MARIN;
    localparam logic [12:0] S_T1 = S_READ | S_MDRIN;
    localparam logic [12:0] S_T2 = S_MDROUT | S_IRIN;
    // ALU word order: {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}
    localparam logic [12:0] A_ADD = 13'h0400, A_MUL = 13'h0100, A_DIV = 13'h0080;
    localparam logic [12:0] A_ROL = 13'h0004, A_NEG = 13'h0002, A_NOT = 13'h0001;

    localparam logic [31:0] IR_ROL = 32'h421B8000;   // ROL R4,R3,R7
    localparam logic [31:0] IR_MUL = 32'h81880000;   // MUL R3,R1
    localparam logic [31:0] IR_NEG = 32'h89280000;   // NEG R2,R5
    localparam logic [31:0] IR_ADD = 32'h18918000;   // ADD R1,R2,R3
    localparam logic [31:0] IR_DIV = 32'h7AB00000;   // DIV R5,R6
    localparam logic [31:0] IR_NOT = 32'h90000000;   // NOT R0,R0
    localparam logic [31:0] IR_BAD = 32'hF8000000;

    typedef struct {
        logic [31:0] ir;
        logic        stop;
        logic [12:0] strb;
        logic [12:0] alu;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        run;
        logic        ill;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic [31:0] i, input logic s, input logic [12:0] st,
                       input logic [12:0] al, input logic [15:0] ro, input logic [15:0] ri,
                       input logic rn, input logic il);
        vec_t v;
        v.ir = i; v.stop = s; v.strb = st; v.alu = al;
        v.rout = ro; v.rin = ri; v.run = rn; v.ill = il;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [12:0] es, input logic [12:0] ea,
                         input logic [15:0] eo, input logic [15:0] ei,
                         input logic er, input logic el);
        logic [12:0] gs, ga;
        gs = {PCin, IncPC, MARin, MDRin, Read, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin};
        ga = {a_and, a_or, a_add, a_sub, a_mul, a_div, a_shr, a_shra, a_shl, a_ror, a_rol, a_neg, a_not};
        n_vec++;
        if ({gs, ga, Rout, Rin, run, illegal} !== {es, ea, eo, ei, er, el}) begin
            n_err++;
            $display("FAIL %s: got strb=%h alu=%h rout=%h rin=%h run=%b ill=%b, expected strb=%h alu=%h rout=%h rin=%h run=%b ill=%b",
                     nm, gs, ga, Rout, Rin, run, illegal, es, ea, eo, ei, er, el);
        end
    endtask

    // Advance one cycle: drive after the edge, sample at the falling edge
    task automatic step(input logic [31:0] i, input logic s);
        @(posedge clk);
        #1;
        ir   = i;
        stop = s;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ir    = 32'h0;
        stop  = 1'b0;

        // Per-cycle expectations starting at the first edge after reset release
        add(32'h0,  0, '0, '0, '0, '0, 0, 0);                       // Reset hold
        add(32'h0,  0, S_T0, '0, '0, '0, 1, 0);
        add(32'h0,  0, S_T1, '0, '0, '0, 1, 0);
        add(32'h0,  0, S_T2, '0, '0, '0, 1, 0);
        add(IR_ROL, 0, S_YIN, '0, 16'h0008, '0, 1, 0);
        add(IR_ROL, 0, S_ZIN, A_ROL, 16'h0080, '0, 1, 0);
        add(IR_ROL, 0, S_ZLO, '0, '0, 16'h0010, 1, 0);
        add(IR_ROL, 0, S_T0, '0, '0, '0, 1, 0);                     // six cycles later
        add(IR_ROL, 0, S_T1, '0, '0, '0, 1, 0);
        add(IR_ROL, 0, S_T2, '0, '0, '0, 1, 0);
        add(IR_MUL, 0, S_YIN, '0, 16'h0008, '0, 1, 0);
        add(IR_MUL, 0, S_ZIN, A_MUL, 16'h0002, '0, 1, 0);
        add(IR_MUL, 0, S_ZLO | S_LOIN, '0, '0, '0, 1, 0);
        add(IR_MUL, 0, S_ZHI | S_HIIN, '0, '0, '0, 1, 0);
        add(IR_MUL, 0, S_T0, '0, '0, '0, 1, 0);
        add(IR_MUL, 0, S_T1, '0, '0, '0, 1, 0);
        add(IR_MUL, 0, S_T2, '0, '0, '0, 1, 0);
        add(IR_NEG, 0, S_ZIN, A_NEG, 16'h0020, '0, 1, 0);
        add(IR_NEG, 0, S_ZLO, '0, '0, 16'h0004, 1, 0);
        add(IR_NEG, 0, S_T0, '0, '0, '0, 1, 0);
        add(IR_NEG, 0, S_T1, '0, '0, '0, 1, 0);
        add(IR_NEG, 0, S_T2, '0, '0, '0, 1, 0);
        add(IR_ADD, 0, S_YIN, '0, 16'h0004, '0, 1, 0);
        add(IR_ADD, 1, S_ZIN, A_ADD, 16'h0008, '0, 1, 0);           // stop mid-instruction
        add(IR_ADD, 1, S_ZLO, '0, '0, 16'h0002, 1, 0);              // still completes
        add(IR_ADD, 1, '0, '0, '0, '0, 0, 0);                       // Halt
        add(IR_ADD, 0, '0, '0, '0, '0, 0, 0);                       // Halt, stop dropped
        add(IR_ADD, 0, S_T0, '0, '0, '0, 1, 0);
        add(IR_ADD, 0, S_T1, '0, '0, '0, 1, 0);
        add(IR_ADD, 0, S_T2, '0, '0, '0, 1, 0);
        add(IR_DIV, 0, S_YIN, '0, 16'h0020, '0, 1, 0);
        add(IR_DIV, 0, S_ZIN, A_DIV, 16'h0040, '0, 1, 0);
        add(IR_DIV, 0, S_ZLO | S_LOIN, '0, '0, '0, 1, 0);
        add(IR_DIV, 0, S_ZHI | S_HIIN, '0, '0, '0, 1, 0);
        add(IR_DIV, 0, S_T0, '0, '0, '0, 1, 0);
        add(IR_DIV, 0, S_T1, '0, '0, '0, 1, 0);
        add(IR_DIV, 0, S_T2, '0, '0, '0, 1, 0);
        add(IR_NOT, 0, S_ZIN, A_NOT, 16'h0001, '0, 1, 0);           // register 0 fields
        add(IR_NOT, 0, S_ZLO, '0, '0, 16'h0001, 1, 0);
        add(IR_NOT, 0, S_T0, '0, '0, '0, 1, 0);
        add(IR_NOT, 0, S_T1, '0, '0, '0, 1, 0);
        add(IR_NOT, 0, S_T2, '0, '0, '0, 1, 0);
        add(IR_BAD, 0, '0, '0, '0, '0, 1, 0);                       // illegal T3
        add(IR_BAD, 0, '0, '0, '0, '0, 0, 1);
        add(IR_BAD, 1, '0, '0, '0, '0, 0, 1);
        add(IR_BAD, 0, '0, '0, '0, '0, 0, 1);
        add(IR_BAD, 0, '0, '0, '0, '0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_low", '0, '0, '0, '0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].ir, tbl[i].stop);
            check($sformatf("row%0d", i), tbl[i].strb, tbl[i].alu, tbl[i].rout,
                  tbl[i].rin, tbl[i].run, tbl[i].ill);
        end

        // Reset clears the sticky illegal flag asynchronously
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_clears_illegal", '0, '0, '0, '0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        stop  = 1'b0;
        step(IR_ADD, 0);
        check("rst2_hold", '0, '0, '0, '0, 0, 0);
        step(IR_ADD, 0);
        check("rst2_t0", S_T0, '0, '0, '0, 1, 0);
        step(IR_ADD, 0);
        check("rst2_t1", S_T1, '0, '0, '0, 1, 0);
        step(IR_ADD, 0);
        check("rst2_t2", S_T2, '0, '0, '0, 1, 0);
        step(IR_ADD, 0);
        check("rst2_t3", S_YIN, '0, 16'h0004, '0, 1, 0);

        // Reset mid-T4 drops outputs before the next edge
        @(posedge clk);
        #1;
        check("mid_t4", S_ZIN, A_ADD, 16'h0008, '0, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_t4_reset", '0, '0, '0, '0, 0, 0);
        @(posedge clk);
        #1;
        check("mid_t4_held", '0, '0, '0, '0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step(IR_ADD, 0);
        check("rst3_hold", '0, '0, '0, '0, 0, 0);
        step(IR_ADD, 0);
        check("rst3_t0", S_T0, '0, '0, '0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
